// File: rtl/instr_decode_stage.sv
// Decode stage of the 8-bit MIPS core: registered control/operand fields, load-use and
// flag hazard stalls, jump flushing and HALT. Optional illegal-opcode trap: ID_ILLEGAL_TRAP_EN.
module instr_decode_stage #(
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [19:0]       ins_in,
    input  logic [7:0]        pc_in,
    input  logic              zero_flag,
    output logic              stall,
    output logic              stall_pm,
    output logic              pc_mux_sel,
    output logic [7:0]        jmp_loc,
    output logic              id_valid,
    output logic [2:0]        id_alu_op,
    output logic [NREG_W-1:0] id_rd,
    output logic [NREG_W-1:0] id_rs,
    output logic [NREG_W-1:0] id_rt,
    output logic [7:0]        id_imm,
    output logic              id_use_imm,
    output logic              id_reg_we,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic              id_sets_flag,
    output logic [7:0]        id_pc,
    output logic              halted,
    output logic              illegal_op,
    output logic [1:0]        dbg_state
);

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LDI  = 5'b01001;
    localparam logic [4:0] OP_LD   = 5'b01010;
    localparam logic [4:0] OP_ST   = 5'b01011;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_JZ   = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        A_ISSUE = 3'd0,
        A_SKIP  = 3'd1,
        A_STALL = 3'd2,
        A_JUMP  = 3'd3,
        A_HALT  = 3'd4
    } act_t;

    state_t state;
    act_t   act;

    logic [4:0] f_op;
    logic [4:0] f_rd;
    logic [4:0] f_rs;
    logic [4:0] f_rt;
    logic [7:0] f_imm;

    logic       is_rtype;
    logic       is_addi;
    logic       is_ld;
    logic       is_st;
    logic       is_jmp;
    logic       is_jz;
    logic       is_halt;
    logic       is_illegal;
    logic [2:0] dec_alu_op;
    logic       dec_use_imm;
    logic       dec_reg_we;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_sets_flag;

    logic       prev_is_ld;
    logic       prev_sets_flag;
    logic [4:0] prev_rd;

    logic       load_use;
    logic       flag_haz;
    logic       trap_halt;
    logic       run_like;

    assign f_op  = ins_in[19:15];
    assign f_rd  = ins_in[14:10];
    assign f_rs  = ins_in[9:5];
    assign f_rt  = ins_in[4:0];
    assign f_imm = ins_in[7:0];

    always_comb begin
        is_rtype      = 1'b0;
        is_addi       = 1'b0;
        is_ld         = 1'b0;
        is_st         = 1'b0;
        is_jmp        = 1'b0;
        is_jz         = 1'b0;
        is_halt       = 1'b0;
        is_illegal    = 1'b0;
        dec_use_imm   = 1'b0;
        dec_reg_we    = 1'b0;
        dec_mem_rd    = 1'b0;
        dec_mem_wr    = 1'b0;
        dec_sets_flag = 1'b0;
        case (f_op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                is_rtype      = 1'b1;
                dec_reg_we    = 1'b1;
                dec_sets_flag = 1'b1;
            end
            OP_ADDI: begin
                is_addi       = 1'b1;
                dec_use_imm   = 1'b1;
                dec_reg_we    = 1'b1;
                dec_sets_flag = 1'b1;
            end
            OP_LDI: begin
                dec_use_imm = 1'b1;
                dec_reg_we  = 1'b1;
            end
            OP_LD: begin
                is_ld      = 1'b1;
                dec_mem_rd = 1'b1;
                dec_reg_we = 1'b1;
            end
            OP_ST: begin
                is_st      = 1'b1;
                dec_mem_wr = 1'b1;
            end
            OP_JMP:  is_jmp  = 1'b1;
            OP_JZ:   is_jz   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
        // An illegal opcode that is not trapped travels down the pipe as a plain NOP.
        dec_alu_op = is_illegal ? 3'b000 : f_op[2:0];
    end

`ifdef ID_ILLEGAL_TRAP_EN
    assign trap_halt = is_illegal;
`else
    assign trap_halt = 1'b0;
`endif

    // Sources: R-type reads rs/rt, ADDI reads rs, ST reads rd as its store data.
    assign load_use = prev_is_ld &&
                      (((is_rtype || is_addi) && (prev_rd == f_rs)) ||
                       (is_rtype && (prev_rd == f_rt)) ||
                       (is_st && (prev_rd == f_rd)));
    assign flag_haz = is_jz && prev_sets_flag;

    // A JZ behind a flag setter must wait: its zero_flag input is not yet meaningful.
    always_comb begin
        act = A_ISSUE;
        if (is_halt || trap_halt) begin
            act = A_HALT;
        end else if (is_jmp || (is_jz && !flag_haz && zero_flag)) begin
            act = A_JUMP;
        end else if (load_use || flag_haz) begin
            act = A_STALL;
        end else if (is_jz) begin
            act = A_SKIP;
        end
    end

    // Handshake: stall is fetch's not-ready; while it is high fetch must present the same
    // ins_in/pc_in next cycle. id_valid qualifies id_* for execute, which never back-pressures.
    assign run_like   = (state == S_RUN) || (state == S_STALL);
    assign stall      = (state == S_HALT) || ((state == S_RUN) && (act == A_STALL));
    assign stall_pm   = stall;
    assign pc_mux_sel = run_like && (act == A_JUMP);
    assign jmp_loc    = f_imm;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_RUN;
            halted         <= 1'b0;
            id_valid       <= 1'b0;
            id_alu_op      <= '0;
            id_rd          <= '0;
            id_rs          <= '0;
            id_rt          <= '0;
            id_imm         <= '0;
            id_use_imm     <= 1'b0;
            id_reg_we      <= 1'b0;
            id_mem_rd      <= 1'b0;
            id_mem_wr      <= 1'b0;
            id_sets_flag   <= 1'b0;
            id_pc          <= '0;
            prev_is_ld     <= 1'b0;
            prev_sets_flag <= 1'b0;
            prev_rd        <= '0;
        end else begin
            // Bubble by default: controls drop, field registers keep their last values.
            id_valid       <= 1'b0;
            id_alu_op      <= '0;
            id_use_imm     <= 1'b0;
            id_reg_we      <= 1'b0;
            id_mem_rd      <= 1'b0;
            id_mem_wr      <= 1'b0;
            id_sets_flag   <= 1'b0;
            prev_is_ld     <= 1'b0;
            prev_sets_flag <= 1'b0;
            case (state)
                S_RUN, S_STALL: begin
                    case (act)
                        A_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        A_JUMP:  state <= S_FLUSH;
                        A_STALL: state <= S_STALL;
                        A_SKIP:  state <= S_RUN;
                        default: begin
                            state          <= S_RUN;
                            id_valid       <= 1'b1;
                            id_alu_op      <= dec_alu_op;
                            id_rd          <= NREG_W'(f_rd);
                            id_rs          <= NREG_W'(f_rs);
                            id_rt          <= NREG_W'(f_rt);
                            id_imm         <= f_imm;
                            id_use_imm     <= dec_use_imm;
                            id_reg_we      <= dec_reg_we;
                            id_mem_rd      <= dec_mem_rd;
                            id_mem_wr      <= dec_mem_wr;
                            id_sets_flag   <= dec_sets_flag;
                            id_pc          <= pc_in;
                            prev_is_ld     <= is_ld;
                            prev_sets_flag <= dec_sets_flag;
                            prev_rd        <= f_rd;
                        end
                    endcase
                end
                S_FLUSH: state <= S_RUN;
                default: state <= S_HALT;
            endcase
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if (run_like && is_illegal) begin
            illegal_op <= 1'b1;
        end
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios followed by a random straight-line
// program scored against an instruction-level model of the decode stage.
module tb_instr_decode_stage;

    typedef struct packed {
        logic       valid;
        logic [2:0] alu;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [7:0] imm;
        logic       use_imm;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       sets_flag;
        logic [7:0] pc;
    } id_t;

    typedef struct packed {
        logic [19:0] ins;
        logic [7:0]  pc;
        logic        stall;
    } cyc_t;

    localparam int ID_W = $bits(id_t);

    logic        clk;
    logic        reset;
    logic [19:0] ins_in;
    logic [7:0]  pc_in;
    logic        zero_flag;
    logic        stall;
    logic        stall_pm;
    logic        pc_mux_sel;
    logic [7:0]  jmp_loc;
    logic        id_valid;
    logic [2:0]  id_alu_op;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [7:0]  id_imm;
    logic        id_use_imm;
    logic        id_reg_we;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic        id_sets_flag;
    logic [7:0]  id_pc;
    logic        halted;
    logic        illegal_op;
    logic [1:0]  dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;

    id_t  last;
    logic exp_halted;
    logic exp_illegal;

    logic [ID_W-1:0] exp_q[$];
    cyc_t            cyc_q[$];

    instr_decode_stage #(.NREG_W(5)) dut (
        .clk(clk), .reset(reset), .ins_in(ins_in), .pc_in(pc_in), .zero_flag(zero_flag),
        .stall(stall), .stall_pm(stall_pm), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_rd(id_rd), .id_rs(id_rs),
        .id_rt(id_rt), .id_imm(id_imm), .id_use_imm(id_use_imm), .id_reg_we(id_reg_we),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_sets_flag(id_sets_flag),
        .id_pc(id_pc), .halted(halted), .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic id_t mk_issue(input logic [19:0] ins, input logic [7:0] pc);
        id_t e;
        logic [4:0] op;
        op = ins[19:15];
        e = '0;
        e.valid = 1'b1;
        e.rd = ins[14:10];
        e.rs = ins[9:5];
        e.rt = ins[4:0];
        e.imm = ins[7:0];
        e.pc = pc;
        case (op)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
                e.alu = op[2:0]; e.reg_we = 1'b1; e.sets_flag = 1'b1;
            end
            5'd8:  begin e.alu = 3'd0; e.use_imm = 1'b1; e.reg_we = 1'b1; e.sets_flag = 1'b1; end
            5'd9:  begin e.alu = 3'd1; e.use_imm = 1'b1; e.reg_we = 1'b1; end
            5'd10: begin e.alu = 3'd2; e.mem_rd = 1'b1; e.reg_we = 1'b1; end
            5'd11: begin e.alu = 3'd3; e.mem_wr = 1'b1; end
            default: e.alu = 3'd0;
        endcase
        return e;
    endfunction

    function automatic id_t bubble_of(input id_t l);
        id_t e;
        e = l;
        e.valid = 1'b0;
        e.alu = 3'd0;
        e.use_imm = 1'b0;
        e.reg_we = 1'b0;
        e.mem_rd = 1'b0;
        e.mem_wr = 1'b0;
        e.sets_flag = 1'b0;
        return e;
    endfunction

    // True when instruction c, fetched straight after p, must wait one cycle.
    function automatic bit needs_stall(input logic [19:0] p, input logic [19:0] c, input bit have_p);
        logic [4:0] po;
        logic [4:0] co;
        logic [4:0] prd;
        bit r_type;
        po = p[19:15];
        co = c[19:15];
        prd = p[14:10];
        r_type = (co >= 5'd1) && (co <= 5'd5);
        if (!have_p) return 1'b0;
        if (co == 5'd17 && (((po >= 5'd1) && (po <= 5'd5)) || po == 5'd8)) return 1'b1;
        if (po != 5'd10) return 1'b0;
        if (r_type) return (prd == c[9:5]) || (prd == c[4:0]);
        if (co == 5'd8) return prd == c[9:5];
        if (co == 5'd11) return prd == c[14:10];
        return 1'b0;
    endfunction

    function automatic logic [19:0] gen_ins();
        logic [4:0] op;
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0, 1, 2, 3: op = 5'($urandom_range(1, 5));
            4:  op = 5'd8;
            5:  op = 5'd9;
            6, 7: op = 5'd10;
            8:  op = 5'd11;
            9:  op = 5'd17;
            10: op = 5'd0;
            default: op = 5'($urandom_range(1, 5));
        endcase
        if (k == 11)
            return {op, 15'($urandom_range(0, 32767))};
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_id(input id_t e);
        chk("id_valid", 32'(id_valid), 32'(e.valid));
        chk("id_alu_op", 32'(id_alu_op), 32'(e.alu));
        chk("id_rd", 32'(id_rd), 32'(e.rd));
        chk("id_rs", 32'(id_rs), 32'(e.rs));
        chk("id_rt", 32'(id_rt), 32'(e.rt));
        chk("id_imm", 32'(id_imm), 32'(e.imm));
        chk("id_use_imm", 32'(id_use_imm), 32'(e.use_imm));
        chk("id_reg_we", 32'(id_reg_we), 32'(e.reg_we));
        chk("id_mem_rd", 32'(id_mem_rd), 32'(e.mem_rd));
        chk("id_mem_wr", 32'(id_mem_wr), 32'(e.mem_wr));
        chk("id_sets_flag", 32'(id_sets_flag), 32'(e.sets_flag));
        chk("id_pc", 32'(id_pc), 32'(e.pc));
        chk("halted", 32'(halted), 32'(exp_halted));
        chk("illegal_op", 32'(illegal_op), 32'(exp_illegal));
    endtask

    // Present one instruction for one cycle; combinational outputs are sampled at negedge.
    task automatic cycle(input logic [19:0] ins, input logic [7:0] pc, input logic zf,
                         input logic exp_stall, input logic exp_mux);
        ins_in = ins;
        pc_in = pc;
        zero_flag = zf;
        @(negedge clk);
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("stall_pm", 32'(stall_pm), 32'(exp_stall));
        chk("pc_mux_sel", 32'(pc_mux_sel), 32'(exp_mux));
        chk("jmp_loc", 32'(jmp_loc), 32'(ins[7:0]));
        @(posedge clk);
        #1;
    endtask

    task automatic step_issue(input logic [19:0] ins, input logic [7:0] pc);
        cycle(ins, pc, 1'b0, 1'b0, 1'b0);
        last = mk_issue(ins, pc);
        check_id(last);
    endtask

    task automatic step_bubble(input logic [19:0] ins, input logic [7:0] pc, input logic zf,
                               input logic exp_stall, input logic exp_mux);
        cycle(ins, pc, zf, exp_stall, exp_mux);
        check_id(bubble_of(last));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ins_in = '0;
        pc_in = '0;
        zero_flag = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last = '0;
        exp_halted = 1'b0;
        exp_illegal = 1'b0;
        check_id('0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [19:0] prev_ins;
        logic [19:0] cur;
        bit          have_prev;
        id_t         e;
        cyc_t        c;

        reset = 1'b1;
        ins_in = '0;
        pc_in = '0;
        zero_flag = 1'b0;
        do_reset();

        // ADD r3,r1,r2
        step_issue(20'h08C22, 8'h00);
        chk("add_alu", 32'(id_alu_op), 32'd1);
        chk("add_rd", 32'(id_rd), 32'd3);

        // LD r4,[0x10] then ADD r5,r4,r1: one stall cycle, one bubble
        step_issue({5'd10, 5'd4, 2'b00, 8'h10}, 8'h01);
        step_bubble({5'd1, 5'd5, 5'd4, 5'd1}, 8'h02, 1'b0, 1'b1, 1'b0);
        step_issue({5'd1, 5'd5, 5'd4, 5'd1}, 8'h02);
        chk("load_use_rs", 32'(id_rs), 32'd4);

        // JMP 0x3C; the flushed slot holds another JMP that must not redirect
        step_bubble({5'd16, 5'd0, 2'b00, 8'h3C}, 8'h03, 1'b0, 1'b0, 1'b1);
        step_bubble({5'd16, 5'd0, 2'b00, 8'h55}, 8'h04, 1'b0, 1'b0, 1'b0);
        step_issue({5'd4, 5'd6, 5'd1, 5'd2}, 8'h3C);

        // ADDI r1,r2 then JZ 0x20 taken; zero_flag high already in the stall cycle
        step_issue({5'd8, 5'd1, 5'd2, 5'd5}, 8'h3D);
        step_bubble({5'd17, 5'd0, 2'b00, 8'h20}, 8'h3E, 1'b1, 1'b1, 1'b0);
        step_bubble({5'd17, 5'd0, 2'b00, 8'h20}, 8'h3E, 1'b1, 1'b0, 1'b1);
        step_bubble({5'd1, 5'd7, 5'd7, 5'd7}, 8'h3F, 1'b0, 1'b0, 1'b0);
        step_issue({5'd5, 5'd2, 5'd3, 5'd4}, 8'h20);

        // Same pattern, JZ not taken
        step_issue({5'd8, 5'd1, 5'd2, 5'd5}, 8'h21);
        step_bubble({5'd17, 5'd0, 2'b00, 8'h40}, 8'h22, 1'b0, 1'b1, 1'b0);
        step_bubble({5'd17, 5'd0, 2'b00, 8'h40}, 8'h22, 1'b0, 1'b0, 1'b0);
        step_issue({5'd2, 5'd3, 5'd1, 5'd2}, 8'h23);

        // Store data register hazard: LD r7 then ST r7
        step_issue({5'd10, 5'd7, 2'b00, 8'h30}, 8'h24);
        step_bubble({5'd11, 5'd7, 2'b00, 8'h31}, 8'h25, 1'b0, 1'b1, 1'b0);
        step_issue({5'd11, 5'd7, 2'b00, 8'h31}, 8'h25);

        // Reset in the middle of a stall clears the load tracking
        step_issue({5'd10, 5'd2, 2'b00, 8'h44}, 8'h26);
        step_bubble({5'd1, 5'd3, 5'd2, 5'd2}, 8'h27, 1'b0, 1'b1, 1'b0);
        do_reset();
        step_issue({5'd1, 5'd3, 5'd2, 5'd2}, 8'h27);

        // HALT holds for a dozen cycles regardless of input, then reset
        exp_halted = 1'b1;
        step_bubble(20'hF8000, 8'h28, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cur = (i % 3 == 0) ? {5'd16, 5'd0, 2'b00, 8'(i)} : gen_ins();
            step_bubble(cur, 8'(8'h29 + i), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        do_reset();

        // Illegal opcode 0b00110
`ifdef ID_ILLEGAL_TRAP_EN
        exp_halted = 1'b1;
        exp_illegal = 1'b1;
        step_bubble({5'd6, 5'd1, 5'd2, 5'd3}, 8'h50, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step_bubble({5'd1, 5'd1, 5'd1, 5'd1}, 8'h51, 1'b0, 1'b1, 1'b0);
        do_reset();
`else
        step_issue({5'd6, 5'd1, 5'd2, 5'd3}, 8'h50);
        chk("illegal_nop_we", 32'(id_reg_we), 32'd0);
        step_issue({5'd1, 5'd1, 5'd2, 5'd3}, 8'h51);
`endif

        // Random straight-line program: build cycle list and expected id stream, then run
        do_reset();
        have_prev = 1'b0;
        prev_ins = '0;
        e = '0;
        for (int k = 0; k < 300; k++) begin
            cur = gen_ins();
            if (needs_stall(prev_ins, cur, have_prev)) begin
                cyc_q.push_back('{ins: cur, pc: 8'(k), stall: 1'b1});
                exp_q.push_back(bubble_of(e));
            end
            cyc_q.push_back('{ins: cur, pc: 8'(k), stall: 1'b0});
            if (cur[19:15] == 5'd17) begin
                exp_q.push_back(bubble_of(e));
            end else begin
                e = mk_issue(cur, 8'(k));
                exp_q.push_back(e);
            end
            prev_ins = cur;
            have_prev = 1'b1;
        end
        while (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            cycle(c.ins, c.pc, 1'b0, c.stall, 1'b0);
            check_id(id_t'(exp_q.pop_front()));
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
